// File: rtl/truth_table_probe.sv
// truth_table_probe: drives every input vector of a small combinational gate
// in ascending order, holds each one for HOLD cycles, samples the gate output
// on the last hold cycle and collects the results into a truth-table word.
// The captured word is presented on table_out, with bit i holding the gate
// output for input value i.
module truth_table_probe #(
    parameter int N_IN = 2,
    parameter int HOLD = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   dut_out,
    output logic [N_IN-1:0]        dut_in,
    output logic                   sample,
    output logic [N_IN-1:0]        vec_idx,
    output logic                   busy,
    output logic                   done,
    output logic [(2**N_IN)-1:0]   table_out
);

    localparam int V  = 2 ** N_IN;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    // Last hold count of a vector; this is the cycle that captures dut_out.
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    // Highest input vector; sampling it ends the run.
    localparam logic [N_IN-1:0] VEC_LAST  = N_IN'(V - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_idx_q, vec_idx_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [V-1:0]    table_q, table_d;
    logic [N_IN-1:0] dut_in_q, dut_in_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sample_s;

    // Sample strobe: the closing edge of this cycle captures dut_out.
    always_comb begin
        sample_s = (state_q == ST_DRIVE) && (hold_cnt_q == HOLD_LAST);
    end

    // Next-state, vector/hold counters and table capture.
    always_comb begin
        state_d    = state_q;
        vec_idx_d  = vec_idx_q;
        hold_cnt_d = hold_cnt_q;
        table_d    = table_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_DRIVE;
                    table_d    = '0;
                    vec_idx_d  = '0;
                    hold_cnt_d = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (sample_s) begin
                    table_d[vec_idx_q] = dut_out;
                    hold_cnt_d         = '0;
                    // Wraps to 0 after the last vector, ready for the next run.
                    vec_idx_d          = vec_idx_q + N_IN'(1);
                    if (vec_idx_q == VEC_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                vec_idx_d  = '0;
                hold_cnt_d = '0;
                table_d    = '0;
            end
        endcase
    end

    // Output decode from the next state so the outputs come straight from flops.
    always_comb begin
        dut_in_d = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            ST_IDLE: begin
                dut_in_d = '0;
            end
            ST_DRIVE: begin
                dut_in_d = vec_idx_d;
                busy_d   = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                dut_in_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_idx_q  <= '0;
            hold_cnt_q <= '0;
            table_q    <= '0;
            dut_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_idx_q  <= vec_idx_d;
            hold_cnt_q <= hold_cnt_d;
            table_q    <= table_d;
            dut_in_q   <= dut_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Port mapping.
    always_comb begin
        dut_in    = dut_in_q;
        sample    = sample_s;
        vec_idx   = vec_idx_q;
        busy      = busy_q;
        done      = done_q;
        table_out = table_q;
    end

endmodule
